// File: rtl/focus_phase_ctrl.sv
// focus_phase_ctrl: focus/break phase scheduler with 1 s prescaler and LED blinker.
// Build option: define LONG_BREAK_EN to give the session's final break LONG_BREAK_SEC.
module focus_phase_ctrl #(
   parameter int CLK_HZ         = 100000000,
   parameter int FOCUS_SEC      = 1500,
   parameter int BREAK_SEC      = 300,
   parameter int ALERT_SEC      = 5,
   parameter int CYCLES         = 4,
   parameter int LONG_BREAK_SEC = 900
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   output logic        led,
   output logic [2:0]  phase,
   output logic [11:0] sec_left,
   output logic [3:0]  cycle_cnt,
   output logic        phase_done
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] BRK_MAX = PW'(CLK_HZ / 2 - 1);
   localparam logic [PW-1:0] ALR_MAX = PW'(CLK_HZ / 8 - 1);

   localparam logic [11:0] FOCUS_LD = 12'(FOCUS_SEC);
   localparam logic [11:0] BREAK_LD = 12'(BREAK_SEC);
   localparam logic [11:0] ALERT_LD = 12'(ALERT_SEC);
   localparam logic [3:0]  CYC_MAX  = 4'(CYCLES);

`ifdef LONG_BREAK_EN
   localparam logic [11:0] LAST_LD = 12'(LONG_BREAK_SEC);
`else
   localparam logic [11:0] LAST_LD = BREAK_LD;
`endif

   if (CLK_HZ < 8 || (CLK_HZ % 8) != 0 ||
       FOCUS_SEC < 1 || FOCUS_SEC > 4095 ||
       BREAK_SEC < 1 || BREAK_SEC > 4095 ||
       ALERT_SEC < 1 || ALERT_SEC > 4095 ||
       CYCLES < 1 || CYCLES > 15 ||
       LONG_BREAK_SEC < 1 || LONG_BREAK_SEC > 4095) begin : g_bad_cfg
      $error("focus_phase_ctrl: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FOCUS  = 3'd1,
      S_BREAK  = 3'd2,
      S_ALERT  = 3'd3,
      S_PAUSED = 3'd4
   } state_t;

   state_t        r_state, w_state;
   state_t        r_saved, w_saved;
   state_t        r_next,  w_next;
   logic [PW-1:0] r_presc, w_presc;
   logic [PW-1:0] r_blink, w_blink;
   logic [PW-1:0] w_bmax;
   logic          r_led,   w_led;
   logic [11:0]   r_sec,   w_sec;
   logic [3:0]    r_cyc,   w_cyc;
   logic          r_done,  w_done;
   logic          w_clr;
   logic          w_active;
   logic          w_tick;
   logic          w_expire;
   logic          w_pause;
   logic          w_start;

   // stop > pause > start; a lower command is dropped when a higher one is present
   assign w_pause  = pause & ~stop;
   assign w_start  = start & ~pause & ~stop;

   assign w_active = (r_state == S_FOCUS) || (r_state == S_BREAK) ||
                     (r_state == S_ALERT);
   assign w_tick   = w_active && (r_presc == PRE_MAX);
   assign w_expire = w_tick && (r_sec == 12'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_saved <= S_IDLE;
         r_next  <= S_IDLE;
         r_presc <= '0;
         r_blink <= '0;
         r_led   <= 1'b0;
         r_sec   <= 12'd0;
         r_cyc   <= 4'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_saved <= w_saved;
         r_next  <= w_next;
         r_presc <= w_presc;
         r_blink <= w_blink;
         r_led   <= w_led;
         r_sec   <= w_sec;
         r_cyc   <= w_cyc;
         r_done  <= w_done;
      end
   end

   always_comb begin
      w_state = r_state;
      w_saved = r_saved;
      w_next  = r_next;
      w_sec   = r_sec;
      w_cyc   = r_cyc;
      w_done  = 1'b0;
      w_clr   = 1'b0;
      w_presc = r_presc;
      if (w_active) begin
         w_presc = w_tick ? '0 : r_presc + PW'(1);
      end
      if (w_tick) begin
         w_sec = r_sec - 12'd1;
      end

      unique case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state = S_FOCUS;
               w_sec   = FOCUS_LD;
               w_cyc   = 4'd0;
               w_clr   = 1'b1;
            end
         end
         S_FOCUS, S_BREAK: begin
            if (stop) begin
               w_state = S_IDLE;
               w_sec   = 12'd0;
               w_cyc   = 4'd0;
               w_clr   = 1'b1;
            end else if (w_pause) begin
               // hold sec_left and prescaler exactly, even on an expiry edge
               w_state = S_PAUSED;
               w_saved = r_state;
               w_sec   = r_sec;
               w_presc = r_presc;
            end else if (w_expire) begin
               w_state = S_ALERT;
               w_sec   = ALERT_LD;
               w_done  = 1'b1;
               w_clr   = 1'b1;
               if (r_state == S_FOCUS) begin
                  w_next = S_BREAK;
                  if (r_cyc != CYC_MAX) begin
                     w_cyc = r_cyc + 4'd1;
                  end
               end else if (r_cyc == CYC_MAX) begin
                  w_next = S_IDLE;
               end else begin
                  w_next = S_FOCUS;
               end
            end
         end
         S_ALERT: begin
            if (stop) begin
               w_state = S_IDLE;
               w_sec   = 12'd0;
               w_cyc   = 4'd0;
               w_clr   = 1'b1;
            end else if (w_expire || w_start) begin
               w_state = r_next;
               w_clr   = 1'b1;
               unique case (r_next)
                  S_FOCUS: w_sec = FOCUS_LD;
                  S_BREAK: w_sec = (r_cyc == CYC_MAX) ? LAST_LD : BREAK_LD;
                  default: w_sec = 12'd0;
               endcase
            end
         end
         S_PAUSED: begin
            if (stop) begin
               w_state = S_IDLE;
               w_sec   = 12'd0;
               w_cyc   = 4'd0;
               w_clr   = 1'b1;
            end else if (w_start) begin
               w_state = r_saved;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_clr   = 1'b1;
         end
      endcase

      if (w_clr) begin
         w_presc = '0;
      end
   end

   always_comb begin
      unique case (r_state)
         S_BREAK: w_bmax = BRK_MAX;
         S_ALERT: w_bmax = ALR_MAX;
         default: w_bmax = PRE_MAX;
      endcase

      w_blink = '0;
      w_led   = r_led;
      if (w_state != r_state) begin
         w_led = (w_state == S_FOCUS) || (w_state == S_BREAK) ||
                 (w_state == S_ALERT);
      end else if ((r_state == S_BREAK) || (r_state == S_ALERT) ||
                   (r_state == S_PAUSED)) begin
         if (r_blink == w_bmax) begin
            w_led = ~r_led;
         end else begin
            w_blink = r_blink + PW'(1);
         end
      end else begin
         w_led = (r_state == S_FOCUS);
      end
   end

   assign led        = r_led;
   assign phase      = r_state;
   assign sec_left   = r_sec;
   assign cycle_cnt  = r_cyc;
   assign phase_done = r_done;

endmodule

// File: tb/tb_focus_phase_ctrl.sv
// tb_focus_phase_ctrl: scoreboard bench for focus_phase_ctrl.
// Reference model tracks remaining active cycles per phase; honours LONG_BREAK_EN.
module tb_focus_phase_ctrl;

   localparam int C  = 8;
   localparam int FS = 3;
   localparam int BS = 2;
   localparam int AS = 1;
   localparam int CY = 2;
   localparam int LS = 4;
`ifdef LONG_BREAK_EN
   localparam int LAST_BS = LS;
`else
   localparam int LAST_BS = BS;
`endif
   localparam int P_IDLE = 0;
   localparam int P_FOC  = 1;
   localparam int P_BRK  = 2;
   localparam int P_ALR  = 3;
   localparam int P_PAU  = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        stop  = 1'b0;
   logic        led;
   logic [2:0]  phase;
   logic [11:0] sec_left;
   logic [3:0]  cycle_cnt;
   logic        phase_done;

   focus_phase_ctrl #(
      .CLK_HZ(C), .FOCUS_SEC(FS), .BREAK_SEC(BS), .ALERT_SEC(AS),
      .CYCLES(CY), .LONG_BREAK_SEC(LS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
      .stop(stop), .led(led), .phase(phase), .sec_left(sec_left),
      .cycle_cnt(cycle_cnt), .phase_done(phase_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        led;
      logic [2:0]  ph;
      logic [11:0] sec;
      logic [3:0]  cyc;
      logic        done;
   } exp_t;

   exp_t q[$];
   int n_vec = 0;
   int n_err = 0;

   int m_ph, m_rem, m_cyc, m_nxt, m_sav, m_t;
   bit m_done;

   int n_done, n_act, n_brk, n_psec, n_ptog, n_foc;

   function automatic void model_reset();
      m_ph = P_IDLE; m_rem = 0; m_cyc = 0;
      m_nxt = P_IDLE; m_sav = P_IDLE; m_t = 0; m_done = 0;
   endfunction

   function automatic int load_of(int p);
      if (p == P_FOC) return FS * C;
      if (p == P_BRK) return ((m_cyc == CY) ? LAST_BS : BS) * C;
      return 0;
   endfunction

   function automatic void end_work();
      m_done = 1;
      if (m_ph == P_FOC) begin
         if (m_cyc < CY) m_cyc++;
         m_nxt = P_BRK;
      end else begin
         m_nxt = (m_cyc == CY) ? P_IDLE : P_FOC;
      end
      m_ph  = P_ALR;
      m_rem = AS * C;
   endfunction

   function automatic void run_alert(bit skip);
      if (!skip) m_rem--;
      if (skip || m_rem == 0) begin
         m_ph  = m_nxt;
         m_rem = load_of(m_nxt);
      end
   endfunction

   function automatic void model_step(bit st, bit pa, bit so);
      int old = m_ph;
      m_done = 0;
      if (so) begin
         if (m_ph != P_IDLE) begin
            m_ph = P_IDLE; m_rem = 0; m_cyc = 0;
         end
      end else if (pa) begin
         if (m_ph == P_FOC || m_ph == P_BRK) begin
            m_sav = m_ph; m_ph = P_PAU;
         end else if (m_ph == P_ALR) begin
            run_alert(0);
         end
      end else begin
         case (m_ph)
            P_IDLE: if (st) begin
               m_ph = P_FOC; m_rem = FS * C; m_cyc = 0;
            end
            P_FOC, P_BRK: begin
               m_rem--;
               if (m_rem == 0) end_work();
            end
            P_ALR: run_alert(st);
            P_PAU: if (st) m_ph = m_sav;
            default: ;
         endcase
      end
      m_t = (m_ph == old) ? m_t + 1 : 0;
   endfunction

   function automatic bit led_of();
      case (m_ph)
         P_FOC:   return 1'b1;
         P_BRK:   return 1'b1 ^ 1'((m_t / (C / 2)) % 2);
         P_ALR:   return 1'b1 ^ 1'((m_t / (C / 8)) % 2);
         P_PAU:   return 1'((m_t / C) % 2);
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t exp_now();
      exp_t e;
      e.led  = led_of();
      e.ph   = 3'(m_ph);
      e.sec  = 12'((m_rem + C - 1) / C);
      e.cyc  = 4'(m_cyc);
      e.done = m_done;
      return e;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(bit st, bit pa, bit so);
      @(negedge clk);
      rst_n = 1'b1;
      start = st; pause = pa; stop = so;
      model_step(st, pa, so);
      q.push_back(exp_now());
   endtask

   task automatic idle(int n);
      repeat (n) cyc(0, 0, 0);
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      rst_n = 1'b0;
      start = 0; pause = 0; stop = 0;
      model_reset();
      q.push_back(exp_now());
      #1;
      chk("async_reset", int'({led, phase, sec_left, cycle_cnt, phase_done}), 0);
      repeat (n - 1) begin
         @(negedge clk);
         q.push_back(exp_now());
      end
   endtask

   initial begin
      exp_t e;
      logic [2:0] pph;
      logic pled;
      pph = 3'd0;
      pled = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            if ({led, phase, sec_left, cycle_cnt, phase_done} !== e) begin
               n_err++;
               $display("FAIL out @%0t: got led=%0b ph=%0d sec=%0d cyc=%0d done=%0b, expected led=%0b ph=%0d sec=%0d cyc=%0d done=%0b",
                        $time, led, phase, sec_left, cycle_cnt, phase_done,
                        e.led, e.ph, e.sec, e.cyc, e.done);
            end
            if (phase_done) n_done++;
            if (phase != 3'd0) n_act++;
            if (phase == 3'd2) n_brk++;
            if (phase == 3'd1) n_foc++;
            if (phase == 3'd4 && sec_left != 12'd2) n_psec++;
            if (phase == 3'd4 && pph == 3'd4 && led != pled) n_ptog++;
         end
         pph = phase;
         pled = led;
      end
   end

   initial begin
      int cnt;
      model_reset();
      do_reset(3);

      n_done = 0; n_act = 0; n_brk = 0;
      cyc(1, 0, 0);
      cnt = 0;
      while (m_ph != P_IDLE && cnt < 400) begin
         cyc(0, 0, 0);
         cnt++;
      end
      idle(2);
      chk("session_done_pulses", n_done, 4);
      chk("session_len", n_act, (2 * FS + 4 * AS + BS + LAST_BS) * C);
      chk("break_len", n_brk, (BS + LAST_BS) * C);
      chk("session_cycle_cnt", int'(cycle_cnt), CY);

      n_psec = 0; n_ptog = 0;
      cyc(1, 0, 0);
      idle(10);
      cyc(0, 1, 0);
      idle(50);
      n_foc = 0;
      cyc(1, 0, 0);
      idle(20);
      chk("pause_sec_frozen", n_psec, 0);
      chk("pause_led_toggles", n_ptog, 6);
      chk("resume_focus_len", n_foc, 14);
      cyc(0, 0, 1);

      cyc(1, 0, 0);
      idle(5);
      cyc(1, 1, 1);
      idle(1);
      cyc(1, 1, 0);
      idle(2);
      chk("pause_start_idle", int'(phase), P_IDLE);
      chk("stop_cycle_cnt", int'(cycle_cnt), 0);

      cyc(1, 0, 0);
      idle(24);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      @(posedge clk);
      #2;
      chk("skip_phase", int'(phase), P_BRK);
      chk("skip_sec", int'(sec_left), BS);
      chk("skip_led", int'(led), 1);

      idle(5);
      n_done = 0;
      do_reset(3);
      cyc(1, 0, 0);
      idle(30);
      chk("reset_then_restart_done", n_done, 1);

      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 99) == 0);
      end
      cyc(0, 0, 0);
      idle(3);

      cnt = 0;
      while (q.size() != 0 && cnt < 10) begin
         @(posedge clk);
         #2;
         cnt++;
      end
      if (q.size() != 0) chk("drain", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
